fb_arbiter: RTL



---
 rtl/fb_pkg.sv | 26 ++
 rtl/vga_delay_line.sv | 42 ++++
 rtl/fb_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared constants and types for the framebuffer arbiter.
//                Holds the framebuffer geometry, the VGA active-area size
//                and the arbiter state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package fb_pkg;

    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int FB_DEPTH = FB_W * FB_H;   // 76800 pixels
    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 8;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_t;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : vga_delay_line
//  Description : Fixed-depth shift register used to re-align the VGA sync
//                signals with the framebuffer read latency.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk    in  1      pixel clock
//    reset  in  1      synchronous active-high reset, clears every stage
//    din    in  WIDTH  value entering the line
//    dout   out WIDTH  din delayed by DEPTH cycles
// ============================================================================
module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign dout = r_stage[DEPTH-1];

endmodule : vga_delay_line
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_arbiter
//  Description : Shares a single-port pixel RAM between VGA scan-out reads
//                and a valid/ready writer, with a built-in clear engine.
//                Even active columns are read slots (display always wins);
//                every other cycle is a write slot. Sync outputs are delayed
//                two cycles to line up with the fetched pixel.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, reset                     pixel clock, synchronous active-high reset
//    hsync_in/vsync_in/video_on_in  timing from the sync generator
//    x, y                           current beam position (800x525 raster)
//    wr_valid/wr_ready              writer handshake
//    wr_addr, wr_data               linear pixel address and value
//    wr_err                         pulse: accepted write was out of range
//    clr_start, clr_color           start a framebuffer fill with clr_color
//    clr_busy, clr_done             fill in progress / fill-finished pulse
//    ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   single-port RAM interface
//    hsync/vsync/video_on/rgb       re-aligned display outputs
// ============================================================================
module fb_arbiter #(
    parameter int FB_W   = fb_pkg::FB_W,
    parameter int FB_H   = fb_pkg::FB_H,
    parameter int ADDR_W = fb_pkg::ADDR_W,
    parameter int DATA_W = fb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              video_on_in,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic [DATA_W-1:0] rgb
);

    import fb_pkg::*;

    localparam logic [ADDR_W-1:0] c_fb_depth  = ADDR_W'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FB_W * FB_H - 1);

    fb_state_t         r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_clr_color;
    logic              r_clr_done;
    logic              r_wr_err;
    logic              r_rd_d1;
    logic [DATA_W-1:0] r_pix;

    logic              w_read_slot;
    logic              w_write_slot;
    logic              w_wr_fire;
    logic              w_wr_in_range;
    logic              w_clr_write;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_row_base;
    logic [ADDR_W-1:0] w_pix_addr;
    logic [2:0]        w_sync_d;
    logic              w_unused_y0;

    // ------------------------------------------------------------------
    // Slot selection and handshake
    // ------------------------------------------------------------------
    assign w_read_slot   = video_on_in && !x[0];
    assign w_write_slot  = !w_read_slot;
    assign wr_ready      = w_write_slot && (r_state == ST_IDLE);
    assign w_wr_fire     = wr_valid && wr_ready;
    assign w_wr_in_range = wr_addr < c_fb_depth;
    assign w_clr_write   = w_write_slot && (r_state == ST_CLEAR);

    // ------------------------------------------------------------------
    // Scan-out address: 2x pixel and line doubling, so the framebuffer
    // row/column are simply y>>1 and x>>1. y[0] only selects which of the
    // two doubled lines is on screen and never reaches the address.
    // ------------------------------------------------------------------
    assign w_row       = ADDR_W'(y[9:1]);
    assign w_col       = ADDR_W'(x[9:1]);
    assign w_unused_y0 = y[0];

    if (FB_W == 320) begin : g_row_mul_shift
        // 320 = 256 + 64, so the row base is two shifts and an add.
        assign w_row_base = (w_row << 8) + (w_row << 6);
    end else begin : g_row_mul_generic
        assign w_row_base = ADDR_W'(w_row * FB_W);
    end

    assign w_pix_addr = w_row_base + w_col;

    // ------------------------------------------------------------------
    // RAM port mux: read slot > clear write > writer transfer
    // ------------------------------------------------------------------
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!reset) begin
            if (w_read_slot) begin
                ram_en   = 1'b1;
                ram_addr = w_pix_addr;
            end else if (w_clr_write) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_clr_cnt;
                ram_wdata = r_clr_color;
            end else if (w_wr_fire && w_wr_in_range) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = wr_addr;
                ram_wdata = wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Clear engine, status pulses and pixel register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
            r_clr_done  <= 1'b0;
            r_wr_err    <= 1'b0;
            r_rd_d1     <= 1'b0;
            r_pix       <= '0;
        end else begin
            r_clr_done <= 1'b0;
            // Out-of-range writes are still accepted so the writer is never
            // stalled; they are simply dropped and flagged a cycle later.
            r_wr_err   <= w_wr_fire && !w_wr_in_range;
            r_rd_d1    <= w_read_slot;
            // RAM data for a read slot arrives one cycle later; the register
            // then holds it across the odd column that shares the pixel.
            if (r_rd_d1) begin
                r_pix <= ram_rdata;
            end

            case (r_state)
                ST_IDLE: begin
                    if (clr_start) begin
                        r_state     <= ST_CLEAR;
                        r_clr_cnt   <= '0;
                        r_clr_color <= clr_color;
                    end
                end
                ST_CLEAR: begin
                    if (w_clr_write) begin
                        if (r_clr_cnt == c_last_addr) begin
                            r_state    <= ST_IDLE;
                            r_clr_cnt  <= '0;
                            r_clr_done <= 1'b1;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign clr_busy = (r_state == ST_CLEAR);
    assign clr_done = r_clr_done;
    assign wr_err   = r_wr_err;

    // ------------------------------------------------------------------
    // Sync re-alignment to the two-cycle pixel path
    // ------------------------------------------------------------------
    vga_delay_line #(
        .DEPTH (2),
        .WIDTH (3)
    ) u_sync_dly (
        .clk   (clk),
        .reset (reset),
        .din   ({hsync_in, vsync_in, video_on_in}),
        .dout  (w_sync_d)
    );

    assign hsync    = w_sync_d[2];
    assign vsync    = w_sync_d[1];
    assign video_on = w_sync_d[0];
    assign rgb      = video_on ? r_pix : '0;

endmodule : fb_arbiter
`default_nettype wire
